// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
//
// Shares one bank of WIDTH JK flip-flops between NUM_REQ requesters. Each
// requester offers a J/K command vector over a valid/ready handshake. A
// round-robin arbiter accepts one command while in IDLE and registers it. On
// the following edge (APPLY) it applies the command to the bank with standard
// JK semantics, pulses done and reports the owner on done_id.
//
// Optional feature: define JK_ARB_LOCK_EN to add req_lock. A locked command
// keeps the round-robin pointer on its owner, so that requester wins the next
// IDLE again if it is still valid. This allows atomic multi-command bursts.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NUM_REQ]        per-requester command valid
//   req_lock   [NUM_REQ]        per-requester lock (JK_ARB_LOCK_EN only)
//   req_j      [NUM_REQ*WIDTH]  J vectors, requester r at [r*WIDTH +: WIDTH]
//   req_k      [NUM_REQ*WIDTH]  K vectors, same packing as req_j
//   req_ready  [NUM_REQ]        one-hot accept, combinational
//   q          [WIDTH]          bank state
//   qbar       [WIDTH]          ~q
//   done                        one-cycle pulse in the cycle q updates
//   done_id    [ID_W]           requester whose command was applied
module jk_bank_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 3,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
`ifdef JK_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  input  logic [NUM_REQ*WIDTH-1:0] req_j,
  input  logic [NUM_REQ*WIDTH-1:0] req_k,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qbar,
  output logic                     done,
  output logic [ID_W-1:0]          done_id
);

  typedef enum logic [0:0] {IDLE = 1'b0, APPLY = 1'b1} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   rr_ptr_next;
  logic [ID_W-1:0]   owner_reg;
  logic [WIDTH-1:0]  cmd_j_reg;
  logic [WIDTH-1:0]  cmd_k_reg;
  logic [WIDTH-1:0]  q_reg;
  logic [WIDTH-1:0]  q_next;
  logic              done_reg;
  logic [ID_W-1:0]   done_id_reg;
`ifdef JK_ARB_LOCK_EN
  logic              lock_reg;
`endif

  logic [WIDTH-1:0]  req_j_arr [NUM_REQ];
  logic [WIDTH-1:0]  req_k_arr [NUM_REQ];
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              handshake;

  // Unpack the flat command buses into per-requester vectors.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_j_arr[gi] = req_j[gi*WIDTH +: WIDTH];
    assign req_k_arr[gi] = req_k[gi*WIDTH +: WIDTH];
  end

  // Per-bit JK update using the registered command.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
    assign q_next[gi] = (cmd_j_reg[gi] & ~q_reg[gi]) | (~cmd_k_reg[gi] & q_reg[gi]);
  end

  // Round-robin search starting at rr_ptr. The candidate index is wrapped
  // explicitly so a non-power-of-2 NUM_REQ never selects a missing requester.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr_reg) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    handshake   = 1'b0;
    req_ready   = '0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          handshake  = 1'b1;
          state_next = APPLY;
          // Gating with rst_n keeps ready low while the bank is held in reset.
          req_ready[grant_idx] = rst_n;
        end
      end
      APPLY: begin
        state_next = IDLE;
`ifdef JK_ARB_LOCK_EN
        if (lock_reg) begin
          rr_ptr_next = owner_reg;
        end else
`endif
        if (owner_reg == ID_W'(NUM_REQ - 1)) begin
          rr_ptr_next = '0;
        end else begin
          rr_ptr_next = owner_reg + ID_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      owner_reg   <= '0;
      cmd_j_reg   <= '0;
      cmd_k_reg   <= '0;
      q_reg       <= '0;
      done_reg    <= 1'b0;
      done_id_reg <= '0;
`ifdef JK_ARB_LOCK_EN
      lock_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      done_reg   <= (state_reg == APPLY);
      if (handshake) begin
        cmd_j_reg <= req_j_arr[grant_idx];
        cmd_k_reg <= req_k_arr[grant_idx];
        owner_reg <= grant_idx;
`ifdef JK_ARB_LOCK_EN
        lock_reg  <= req_lock[grant_idx];
`endif
      end
      if (state_reg == APPLY) begin
        q_reg       <= q_next;
        done_id_reg <= owner_reg;
      end
    end
  end

  assign q       = q_reg;
  assign qbar    = ~q_reg;
  assign done    = done_reg;
  assign done_id = done_id_reg;

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one bank of WIDTH JK flip-flops between NUM_REQ requesters.
- Each requester presents a J/K command vector using a valid/ready handshake.
- A round-robin arbiter accepts one command at a time, registers it, then applies it to the bank using standard JK semantics.
- Sits between control agents and the shared JK state register. It replaces direct j/k drive when more than one agent needs the flops.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank (1..32).
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, derived: $clog2(NUM_REQ), minimum 1. Localparam only, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_j  in  NUM_REQ*WIDTH  J vectors; requester r occupies bits [r*WIDTH +: WIDTH].
- req_k  in  NUM_REQ*WIDTH  K vectors, same packing as req_j.
- req_ready  out  NUM_REQ  one-hot accept; combinational from state, rr_ptr and req_valid.
- q  out  WIDTH  bank state.
- qbar  out  WIDTH  always equal to ~q.
- done  out  1  one-cycle pulse in the cycle q updates.
- done_id  out  ID_W  index of the requester whose command was applied.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All flops clear immediately on rst_n low.
- Reset values: q=0, qbar=all ones, state=IDLE, rr_ptr=0, done=0, done_id=0. req_ready=0 while rst_n is low.
- FSM states: IDLE and APPLY.
- IDLE, no request: if no req_valid bit is set, req_ready=0 and the FSM stays in IDLE.
- IDLE, arbitration: g = first r with req_valid[r]=1, searching from rr_ptr upward and wrapping at NUM_REQ-1 -> 0.
- IDLE, accept: req_ready = one-hot g. On that edge:
  - cmd_j/cmd_k <= requester g's vectors;
  - owner <= g;
  - state <= APPLY.
- APPLY, bank update (per bit i):
  - j=0, k=0: hold.
  - j=1, k=0: set.
  - j=0, k=1: clear.
  - j=1, k=1: toggle.
  - Equivalently q[i] <= (cmd_j[i] & ~q[i]) | (~cmd_k[i] & q[i]).
- APPLY, same edge:
  - done <= 1; done_id <= owner;
  - rr_ptr <= owner+1, wrapping NUM_REQ-1 -> 0;
  - state <= IDLE.
- done deasserts on the following edge unless another APPLY occurs.
- APPLY, ready: req_ready=0 throughout APPLY.
- Latency and throughput:
  - Handshake edge to q update is 1 cycle.
  - Maximum throughput is one command per 2 cycles.
- Handshake rules:
  - Requester holds req_valid and its vectors stable until it sees req_ready.
  - Deasserting valid before acceptance withdraws the request with no side effect.
  - Vectors are sampled only on the handshake edge.
- Simultaneous requests: exactly one is accepted, per round-robin. Losers keep valid asserted and are served in rotation. No requester waits more than NUM_REQ commands.
- rr_ptr out of range: cannot occur. Wrap is explicit; a non-power-of-2 NUM_REQ never indexes past NUM_REQ-1.
- Reset during APPLY: the command is discarded, q=0, no done pulse, FSM returns to IDLE.

Optional Feature:
- Macro: JK_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock [NUM_REQ].
  - If req_lock[g]=1 on the handshake edge, APPLY leaves rr_ptr=owner instead of owner+1. The same requester therefore wins the next IDLE if still valid, allowing atomic multi-command bursts.
  - If the locked owner is not valid in the next IDLE, normal search from rr_ptr applies.
- When undefined: the req_lock port does not exist and rr_ptr always advances to owner+1.

Test Plan:
- Reset check (WIDTH=4, NUM_REQ=3): rst_n=0 asynchronously -> q=0000, qbar=1111, req_ready=000, done=0; these hold until release.
- Single set: after reset, req0 valid with j=0011, k=0000 -> req_ready=001 in the IDLE cycle; next edge q=0011, done=1, done_id=0.
- Mixed JK: from q=0011, req1 with j=0101, k=0110 -> q=0101 (bit2 toggles, bit1 clears, bit0 set, bit3 holds); qbar=1010, done_id=1.
- Contention: all three requesters valid continuously from reset -> done_id sequence 0,1,2,0,1 with done every 2nd cycle, and req_ready never multi-hot.
- Reset mid-operation: assert rst_n=0 in the APPLY cycle of req2 command j=1111 -> q=0000, no done pulse, FSM in IDLE after release.
- Lock (JK_ARB_LOCK_EN defined): req0 with lock=1 and toggle j=k=0001, req1 also valid -> req0 granted twice consecutively (q bit0 0->1->0). Then req0 lock=0 -> req1 granted next.
